// File: rtl/mig_line_reader.sv
// Reads one line of DATA_W words from a Xilinx MIG user interface into a credit-guarded FIFO
// and streams it out. Define MIG_LINE_READER_STATS_EN to add the stall_cnt port.
module mig_line_reader #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 128,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_calib_complete,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       num_words,
  output logic              busy,
  output logic              done,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        dbg_state
`ifdef MIG_LINE_READER_STATS_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       issued_q, issued_d;
  logic [15:0]       returned_q, returned_d;
  logic [15:0]       nw_q, nw_d;
  logic [CW-1:0]     credits_q, credits_d;
  logic [ADDR_W-1:0] app_addr_q, app_addr_d;
  logic              app_en_q, app_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [CW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic start_acc;
  logic cmd_acc;
  logic pop;
  logic wr_en;
  logic fifo_empty;
  logic fifo_full;

  // Handshakes: a MIG command transfers on a cycle with app_en && app_rdy, and
  // a stream word transfers on a cycle with m_valid && m_ready; a presented
  // command holds its address until it transfers.
  assign start_acc  = (state_q == S_IDLE) && start && init_calib_complete;
  assign cmd_acc    = app_en_q && app_rdy;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign pop        = !fifo_empty && m_ready;
  // Returns seen while idle belong to an abandoned line and are dropped.
  assign wr_en      = app_rd_data_valid && (state_q != S_IDLE);

  assign busy      = busy_q;
  assign done      = done_q;
  assign app_en    = app_en_q;
  assign app_cmd   = 3'b001;
  assign app_addr  = app_addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = mem_q[rd_ptr_q[PW-1:0]];
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    nw_d       = nw_q;
    app_addr_d = app_addr_q;
    done_d     = 1'b0;
    credits_d  = credits_q;
    wr_ptr_d   = wr_ptr_q + CW'(wr_en);
    rd_ptr_d   = rd_ptr_q + CW'(pop);

    if (cmd_acc && !pop) begin
      credits_d = credits_q - CW'(1);
    end else if (!cmd_acc && pop) begin
      credits_d = credits_q + CW'(1);
    end
    if (cmd_acc) begin
      issued_d   = issued_q + 16'd1;
      app_addr_d = app_addr_q + ADDR_W'(8);
    end
    if (wr_en) begin
      returned_d = returned_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          nw_d       = num_words;
          issued_d   = 16'd0;
          returned_d = 16'd0;
          if (num_words == 16'd0) begin
            done_d = 1'b1;
          end else begin
            app_addr_d = base_addr;
            state_d    = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (cmd_acc && (issued_d == nw_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((returned_q == nw_q) && fifo_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // A stalled command stays up regardless of calibration; otherwise look ahead
    // at next-cycle counts so a request goes out the cycle after start.
    if (app_en_q && !app_rdy) begin
      app_en_d = 1'b1;
    end else begin
      app_en_d = (state_d == S_ISSUE) && (issued_d < nw_d) &&
                 (credits_d != '0) && init_calib_complete;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      issued_q   <= '0;
      returned_q <= '0;
      nw_q       <= '0;
      credits_q  <= CW'(DEPTH);
      app_addr_q <= '0;
      app_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      nw_q       <= nw_d;
      credits_q  <= credits_d;
      app_addr_q <= app_addr_d;
      app_en_q   <= app_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[PW-1:0]] <= app_rd_data;
    end
  end

  // Credits bound outstanding reads to free FIFO space, so this cannot fire.
  always @(posedge clk) begin
    if (!rst && wr_en) begin
      assert (!fifo_full);
    end
  end

`ifdef MIG_LINE_READER_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_acc) begin
      stall_cnt_d = 32'd0;
    end else if (app_en_q && !app_rdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mig_line_reader.sv
// Directed + randomized bench for mig_line_reader: a MIG read model returns a
// hashed word per address in order, and a scoreboard checks addresses and stream data.
module tb_mig_line_reader;
  localparam int ADDR_W = 29;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init_calib_complete = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       num_words = '0;
  logic              busy, done, app_en, m_valid;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rdy = 1'b0;
  logic [DATA_W-1:0] app_rd_data = '0;
  logic              app_rd_data_valid = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic [1:0]        dbg_state;
`ifdef MIG_LINE_READER_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  mig_line_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .start(start), .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rdy(app_rdy), .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .dbg_state(dbg_state)
`ifdef MIG_LINE_READER_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cmd_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 1;
  int mrdy_mode = 1;
  int lat_max = 3;
  logic [31:0]       salt;
  logic [ADDR_W-1:0] last_cmd_addr = '0;
  logic              wrote_prev = 1'b0;
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] hold_data = '0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_t;
  rd_t mig_q[$];

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E37_79B1) ^ salt;
    return {h, ~h, h ^ 32'h5A5A_5A5A, 32'(a)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- MIG / sink driver ----------------
  task automatic drive_mig(input logic line_live);
    app_rd_data_valid = 1'b0;
    if (mig_q.size() > 0 && mig_q[0].due <= cyc) begin
      app_rd_data       = mig_q[0].data;
      app_rd_data_valid = 1'b1;
      void'(mig_q.pop_front());
    end
    wrote_prev = app_rd_data_valid && line_live;
    app_rdy = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    m_ready = (mrdy_mode == 2) ? ($urandom_range(0, 1) == 1) : (mrdy_mode == 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    if (!rst && wrote_prev) check("m_valid_after_write", m_valid, 1'b1);
    if (!rst && prev_hold) check("m_data_hold", m_data, hold_data);
    drive_mig(busy && !rst);
    if (rst) begin
      exp_addr_q.delete();
      exp_q.delete();
      cmd_cnt   = 0;
      pop_cnt   = 0;
      prev_hold = 1'b0;
    end else begin
      if (start && init_calib_complete && !busy) begin
        for (int i = 0; i < int'(num_words); i++) begin
          ea = base_addr + ADDR_W'(8 * i);
          exp_addr_q.push_back(ea);
          exp_q.push_back(mem_word(ea));
        end
      end
      if (app_en && app_rdy) begin
        if (exp_addr_q.size() > 0) ea = exp_addr_q.pop_front();
        else ea = 'x;
        check("cmd_addr", app_addr, ea);
        mig_q.push_back('{mem_word(app_addr), cyc + 1 + $urandom_range(0, lat_max)});
        cmd_cnt++;
        last_cmd_addr = app_addr;
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) ed = exp_q.pop_front();
        else ed = 'x;
        check("m_data", m_data, ed);
        pop_cnt++;
      end
      check("inflight_le_depth", (cmd_cnt - pop_cnt) <= DEPTH, 1'b1);
      if (done) begin
        done_cnt++;
        check("done_with_busy_low", busy, 1'b0);
      end
      prev_hold = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [ADDR_W-1:0] b, input int n);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    num_words = n[15:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #2;
      if (done_cnt != d0) break;
    end
    check($sformatf("%s_done_seen", tag), done_cnt != d0, 1'b1);
  endtask

  task automatic run_line(input logic [ADDR_W-1:0] b, input int n, input string tag);
    int d0, c0, p0;
    d0 = done_cnt; c0 = cmd_cnt; p0 = pop_cnt;
    start_line(b, n);
    wait_done(d0, 4000, tag);
    repeat (2) @(posedge clk);
    #2;
    check($sformatf("%s_done_pulses", tag), done_cnt - d0, 1);
    check($sformatf("%s_cmds", tag), cmd_cnt - c0, n);
    check($sformatf("%s_words", tag), pop_cnt - p0, n);
    check($sformatf("%s_scoreboard_empty", tag), exp_q.size(), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int d0, c0, p0, k;
    logic [ADDR_W-1:0] a0;
    salt = $urandom;

    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_app_en", app_en, 1'b0);
    check("rst_app_addr", app_addr, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("app_cmd_read", app_cmd, 3'b001);
    @(posedge clk); #1;
    rst = 1'b0;

    // start with calibration low is ignored
    d0 = done_cnt;
    start_line(29'h40, 4);
    repeat (5) @(posedge clk);
    #2;
    check("nocal_busy", busy, 1'b0);
    check("nocal_cmds", cmd_cnt, 0);
    check("nocal_done", done_cnt - d0, 0);
    init_calib_complete = 1'b1;

    // basic line and address sequence
    run_line(29'h100, 4, "basic");
    check("basic_last_addr", last_cmd_addr, 29'h118);

    // address wrap
    run_line({ADDR_W{1'b1}} << 3, 2, "wrap");
    check("wrap_second_addr", last_cmd_addr, '0);

    // credit limit with a stalled sink
    mrdy_mode = 0;
    d0 = done_cnt; c0 = cmd_cnt; p0 = pop_cnt;
    start_line(29'h4000, 100);
    repeat (200) @(posedge clk);
    #2;
    check("credit_cmds_at_limit", cmd_cnt - c0, DEPTH);
    check("credit_app_en_low", app_en, 1'b0);
    check("credit_m_valid", m_valid, 1'b1);
    mrdy_mode = 1;
    wait_done(d0, 4000, "credit");
    repeat (2) @(posedge clk);
    #2;
    check("credit_cmds_total", cmd_cnt - c0, 100);
    check("credit_words_total", pop_cnt - p0, 100);

    // app_rdy stall holds the address
    rdy_mode = 0;
    d0 = done_cnt;
    start_line(29'h2340, 3);
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (app_en) break;
    end
    check("stall_app_en_up", app_en, 1'b1);
    a0 = app_addr;
    check("stall_first_addr", a0, 29'h2340);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_app_en_held", app_en, 1'b1);
      check("stall_addr_held", app_addr, 29'h2340);
    end
    rdy_mode = 1;
    wait_done(d0, 500, "stall");
    repeat (2) @(posedge clk);
    #2;
`ifdef MIG_LINE_READER_STATS_EN
    check("stall_cnt", stall_cnt, 32'd5);
`endif
    check("stall_words", exp_q.size(), 0);

    // start while busy is ignored
    d0 = done_cnt; c0 = cmd_cnt; p0 = pop_cnt;
    start_line(29'h2000, 8);
    repeat (2) @(posedge clk);
    #2;
    check("busy_during_line", busy, 1'b1);
    start_line(29'h9000, 5);
    wait_done(d0, 500, "busy_start");
    repeat (4) @(posedge clk);
    #2;
    check("busy_start_pulses", done_cnt - d0, 1);
    check("busy_start_cmds", cmd_cnt - c0, 8);
    check("busy_start_words", pop_cnt - p0, 8);

    // zero-length line: done one cycle after start, no command
    c0 = cmd_cnt;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 29'h7000; num_words = 16'd0;
    #3;
    check("zero_done_before", done, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    #2;
    check("zero_done_pulse", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_app_en", app_en, 1'b0);
    @(posedge clk); #2;
    check("zero_done_single", done, 1'b0);
    check("zero_no_cmd", cmd_cnt - c0, 0);

    // reset mid-line abandons it and discards late returns
    mrdy_mode = 0;
    c0 = cmd_cnt;
    start_line(29'h800, 10);
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (cmd_cnt - c0 >= 4) break;
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_app_en", app_en, 1'b0);
    check("midrst_app_addr", app_addr, '0);
    check("midrst_m_valid", m_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(posedge clk); #2;
      if (mig_q.size() == 0) break;
    end
    check("midrst_returns_drained", mig_q.size(), 0);
    repeat (3) @(posedge clk);
    #2;
    check("midrst_discard_m_valid", m_valid, 1'b0);
    check("midrst_idle", busy, 1'b0);
    mrdy_mode = 1;
    run_line(29'h500, 2, "after_rst");

    // randomized lines
    for (int r = 0; r < 6; r++) begin
      rdy_mode  = 2;
      mrdy_mode = 2;
      lat_max   = $urandom_range(0, 5);
      run_line(ADDR_W'($urandom), $urandom_range(1, 90), $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
